// File: rtl/mux81_rr.sv
// Eight-lane round-robin merge onto one registered ready/valid output channel.
// out_sel tags each beat with its source lane so a downstream demux can steer it back.
module mux81_rr #(
    parameter int W = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [8*W-1:0] in_data,
    input  logic [7:0]     in_valid,
    output logic [7:0]     in_ready,
    output logic [W-1:0]   out_data,
    output logic [2:0]     out_sel,
    output logic           out_valid,
    input  logic           out_ready
);

    logic [2:0]   ptr_reg;
    logic         out_valid_reg;
    logic [W-1:0] out_data_reg;
    logic [2:0]   out_sel_reg;

    logic         free;
    logic         do_grant;
    logic [2:0]   grant;
    logic [W-1:0] lane [8];

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_lane
            assign lane[gi]     = in_data[gi*W +: W];
            assign in_ready[gi] = do_grant && (grant == 3'(gi));
        end
    endgenerate

    assign free     = !out_valid_reg || out_ready;
    assign do_grant = free && (in_valid != 8'h00) && !rst;

    // Scan from the farthest offset down so the nearest valid lane past ptr wins.
    always_comb begin
        grant = ptr_reg;
        for (int k = 7; k >= 0; k--) begin
            if (in_valid[ptr_reg + 3'(k)]) begin
                grant = ptr_reg + 3'(k);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_reg       <= 3'd0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_sel_reg   <= 3'd0;
        end else if (do_grant) begin
            out_data_reg  <= lane[grant];
            out_sel_reg   <= grant;
            out_valid_reg <= 1'b1;
            ptr_reg       <= grant + 3'd1;
        end else if (free) begin
            out_valid_reg <= 1'b0;
        end
    end

    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign out_sel   = out_sel_reg;

endmodule
